// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types for the load/store stage.
// Access size and FSM state encodings.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } mac_state_t;

  // Size code 11 is an alias of word.
  function automatic logic [1:0] eff_size(
    input logic [1:0] sz
  );
    return (sz == 2'b11) ? 2'b10 : sz;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: request/acknowledge data-memory bus.
// master = load/store unit, slave = memory.
interface mem_access_if #(
  parameter int N = 32
) ();
  localparam int L = N / 8;

  logic         bus_req;
  logic         bus_we;
  logic [N-1:0] bus_addr;
  logic [L-1:0] bus_be;
  logic [N-1:0] bus_wdata;
  logic         bus_ack;
  logic [N-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half from a bus word
// and sign- or zero-extends it. Little-endian lanes.
module mem_load_align
  import mem_access_pkg::*;
#(
  parameter int N = 32,
  localparam int K = $clog2(N / 8)
) (
  input  logic [N-1:0] bus_rdata,
  input  logic [K-1:0] lane,
  input  logic [1:0]   size,
  input  logic         is_unsigned,
  output logic [N-1:0] ext_data
);

  logic [K+2:0] bit_ofs;
  logic [7:0]   b;
  logic [15:0]  h;

  assign bit_ofs = {lane, 3'b000};
  assign b       = bus_rdata[bit_ofs +: 8];
  assign h       = bus_rdata[bit_ofs +: 16];

  always_comb begin
    ext_data = bus_rdata;
    unique case (1'b1)
      size == SZ_BYTE:
        ext_data = {{(N-8){~is_unsigned & b[7]}}, b};
      size == SZ_HALF:
        ext_data = {{(N-16){~is_unsigned & h[15]}}, h};
      default:
        ext_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage with one req/ack bus transaction per op.
// Define MEM_ACCESS_SUBWORD_EN for byte/half accesses; otherwise word-only.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] write_data,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_size,
  input  logic         mem_unsigned,
  output logic         stall,
  output logic [N-1:0] read_data,
  output logic         misaligned,
  mem_access_if.master bus
);

  localparam int L = N / 8;
  localparam int K = $clog2(L);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [L-1:0] BE_ALL = '1;

  logic [1:0]   state;
  logic         op;
  logic         aligned;
  logic         go;
  logic         ld_only;
  logic [K-1:0] lane;
  logic [L-1:0] be_n;
  logic [N-1:0] wdata_n;
  logic [N-1:0] ld_data;

  logic         q_req;
  logic         q_we;
  logic [N-1:0] q_addr;
  logic [L-1:0] q_be;
  logic [N-1:0] q_wdata;
  logic         r_rd;
  logic         r_we;

  assign lane    = addr[K-1:0];
  assign op      = mem_read | mem_write;
  assign ld_only = mem_read & ~mem_write;
  assign go      = (state == ST_IDLE) & op & aligned;

  assign stall = ~reset & (go | (state == ST_REQ));
  assign misaligned =
    ~reset & (state == ST_IDLE) & op & ~aligned;

`ifdef MEM_ACCESS_SUBWORD_EN
  localparam logic [L-1:0] BE_ONE = L'(1);
  localparam logic [L-1:0] BE_TWO = L'(3);

  logic [1:0]   sz;
  logic [K-1:0] r_lane;
  logic [1:0]   r_size;
  logic         r_uns;

  assign sz = eff_size(mem_size);

  always_comb begin
    aligned = 1'b1;
    be_n    = BE_ALL;
    wdata_n = write_data;
    unique case (1'b1)
      sz == SZ_BYTE: begin
        be_n    = BE_ONE << lane;
        wdata_n = {L{write_data[7:0]}};
      end
      sz == SZ_HALF: begin
        aligned = ~addr[0];
        be_n    = BE_TWO << lane;
        wdata_n = {(L/2){write_data[15:0]}};
      end
      default: aligned = (lane == '0);
    endcase
  end

  // Formatting info is latched so the CPU may change inputs mid-access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane <= '0;
      r_size <= 2'b10;
      r_uns  <= 1'b0;
    end else if (go) begin
      r_lane <= lane;
      r_size <= sz;
      r_uns  <= mem_unsigned;
    end
  end

  mem_load_align #(
    .N(N)
  ) u_align (
    .bus_rdata  (bus.bus_rdata),
    .lane       (r_lane),
    .size       (r_size),
    .is_unsigned(r_uns),
    .ext_data   (ld_data)
  );
`else
  logic unused_cfg;

  assign unused_cfg = ^{mem_size, mem_unsigned};
  assign aligned    = (lane == '0);
  assign be_n       = BE_ALL;
  assign wdata_n    = write_data;
  assign ld_data    = bus.bus_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      q_req     <= 1'b0;
      q_we      <= 1'b0;
      q_addr    <= '0;
      q_be      <= '0;
      q_wdata   <= '0;
      r_rd      <= 1'b0;
      r_we      <= 1'b0;
      read_data <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            q_req   <= 1'b1;
            q_we    <= mem_write;
            q_addr  <= {addr[N-1:K], {K{1'b0}}};
            q_be    <= be_n;
            q_wdata <= wdata_n;
            r_rd    <= mem_read;
            r_we    <= mem_write;
            state   <= ST_REQ;
          end else if (op & ~aligned & ld_only) begin
            read_data <= '0;
          end
        end
        ST_REQ: begin
          if (bus.bus_ack) begin
            q_req <= 1'b0;
            if (r_rd) read_data <= r_we ? '0 : ld_data;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = q_req;
  assign bus.bus_we    = q_we;
  assign bus.bus_addr  = q_addr;
  assign bus.bus_be    = q_be;
  assign bus.bus_wdata = q_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for the load/store stage.
// Covers both MEM_ACCESS_SUBWORD_EN builds.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        stall;
  logic [31:0] read_data;
  logic        misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb[$];

  mem_access_if #(.N(32)) bus ();

  mem_access_unit #(
    .N(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .write_data  (write_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_size    (mem_size),
    .mem_unsigned(mem_unsigned),
    .stall       (stall),
    .read_data   (read_data),
    .misaligned  (misaligned),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_rd(input string tag);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      check(tag, read_data, sb.pop_front());
    end
  endtask

  task automatic drive(
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic        rd,
    input logic        wr,
    input logic [1:0]  sz,
    input logic        uns
  );
    addr         = a;
    write_data   = wd;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = uns;
  endtask

  task automatic access(
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic        rd,
    input logic        wr,
    input logic [1:0]  sz,
    input logic        uns,
    input int          waits,
    input logic [31:0] rdata,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wd,
    input logic [31:0] exp_rd
  );
    int nstall;
    sb.push_back(exp_rd);
    @(posedge clk); #1;
    drive(a, wd, rd, wr, sz, uns);
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_mis", 32'(misaligned), 32'd0);
    nstall = stall ? 1 : 0;
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = rdata;
      end
      @(negedge clk);
      if (stall) nstall++;
      check("req", 32'(bus.bus_req), 32'd1);
      check("baddr", bus.bus_addr, {a[31:2], 2'b00});
      check("bwe", 32'(bus.bus_we), 32'(wr));
      if (wr) begin
        check("bbe", 32'(bus.bus_be), 32'(exp_be));
        check("bwdata", bus.bus_wdata, exp_wd);
      end
      @(posedge clk); #1;
    end
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = $urandom;
    @(negedge clk);
    check("done_stall", 32'(stall), 32'd0);
    check("done_req", 32'(bus.bus_req), 32'd0);
    check("stall_cycles", 32'(nstall), 32'(waits + 2));
    pop_rd("rdata");
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("no_relaunch", 32'(bus.bus_req | stall), 32'd0);
  endtask

  task automatic mis_access(
    input logic [31:0] a,
    input logic [1:0]  sz
  );
    sb.push_back(32'd0);
    @(posedge clk); #1;
    drive(a, 32'h0, 1'b1, 1'b0, sz, 1'b0);
    @(negedge clk);
    check("mis_pulse", 32'(misaligned), 32'd1);
    check("mis_stall", 32'(stall), 32'd0);
    check("mis_req", 32'(bus.bus_req), 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("mis_end", 32'(misaligned), 32'd0);
    check("mis_req2", 32'(bus.bus_req), 32'd0);
    pop_rd("mis_rdata");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rv;
    int          w;

    reset         = 1'b1;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(bus.bus_req), 32'd0);
    check("rst_we", 32'(bus.bus_we), 32'd0);
    check("rst_addr", bus.bus_addr, 32'd0);
    check("rst_be", 32'(bus.bus_be), 32'd0);
    check("rst_wdata", bus.bus_wdata, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);

    // Stray ack with no request must do nothing.
    @(posedge clk); #1;
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'h1111_2222;
    @(negedge clk);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    check("stray_req", 32'(bus.bus_req), 32'd0);
    check("stray_stall", 32'(stall), 32'd0);
    check("stray_rdata", read_data, 32'd0);

    access(32'h104, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 2,
           32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    access(32'h4, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 0,
           32'h89AB_CDEF, 4'b0, 32'h0, 32'h89AB_CDEF);
    mis_access(32'h2, 2'b10);
    access(32'h8, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1,
           32'h1234_5678, 4'b0, 32'h0, 32'h1234_5678);
    mis_access(32'h1, 2'b01);
    access(32'hC, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 0,
           32'hCAFE_F00D, 4'b0, 32'h0, 32'hCAFE_F00D);
    access(32'h20, 32'h5555_AAAA, 1'b1, 1'b1, 2'b10, 1'b0, 1,
           32'h7777_7777, 4'b1111, 32'h5555_AAAA, 32'h0);
    access(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 0,
           32'hA5A5_0001, 4'b0, 32'h0, 32'hA5A5_0001);

    // Abort a request with reset, then reissue it.
    @(posedge clk); #1;
    drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_req_pre", 32'(bus.bus_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_req", 32'(bus.bus_req), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_rdata", read_data, 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    access(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 0,
           32'h0F0F_0F0F, 4'b0, 32'h0, 32'h0F0F_0F0F);

    for (int i = 0; i < 4; i++) begin
      ra = {$urandom_range(0, 32'h3FFF), 2'b00};
      rv = $urandom;
      w  = $urandom_range(0, 3);
      access(ra, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, w,
             rv, 4'b0, 32'h0, rv);
    end

`ifdef MEM_ACCESS_SUBWORD_EN
    access(32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 0,
           32'h8000_0000, 4'b0, 32'h0, 32'hFFFF_FF80);
    access(32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 0,
           32'h8000_0000, 4'b0, 32'h0, 32'h0000_0080);
    access(32'h22, 32'h0000_1234, 1'b0, 1'b1, 2'b01, 1'b0, 0,
           32'h0, 4'b1100, 32'h1234_1234, 32'h0000_0080);
    access(32'h2, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1,
           32'h8001_0000, 4'b0, 32'h0, 32'hFFFF_8001);
    access(32'h2, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 0,
           32'h8001_0000, 4'b0, 32'h0, 32'h0000_8001);
    access(32'h101, 32'h0000_00A5, 1'b0, 1'b1, 2'b00, 1'b0, 0,
           32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8001);
    access(32'hC, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 0,
           32'h1357_9BDF, 4'b0, 32'h0, 32'h1357_9BDF);
    mis_access(32'h3, 2'b01);
`else
    mis_access(32'h1, 2'b00);
    access(32'h4, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1,
           32'h8000_0080, 4'b0, 32'h0, 32'h8000_0080);
    access(32'h8, 32'h1122_3344, 1'b0, 1'b1, 2'b00, 1'b0, 0,
           32'h0, 4'b1111, 32'h1122_3344, 32'h8000_0080);
    mis_access(32'h3, 2'b00);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
